spi_s_regfile: RTL

- SPI slave that terminates the 16-bit frames produced by the team's SPI master: samples CSN/SCLK/MOSI, drives MISO, and serves a small byte-wide register file.
- Sits directly downstream of the SPI master on the same board-level clock domain.
- All SPI inputs are oversampled by CLK; SCLK is treated as data, not as a clock.
- Frame format, MSB first: bit15 = Mode (1 = write, 0 = read), bits14:8 = Addr[6:0], bits7:0 = data (write data, or don't-care on read).

---
 rtl/spi_s_regfile.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_s_regfile.sv
// SPI mode-0 slave serving a byte-wide register file; SCLK/CSN/MOSI are oversampled on CLK.
// Optional SPI_S_ERR_CNT_EN adds a saturating abort counter (ERR_CNT) cleared by writing 8'hA5 to 7'h7F.
module spi_s_regfile #(
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       CSN,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  output logic       BUSY,
  output logic       REG_WR_STB,
  output logic [6:0] REG_WR_ADDR,
  output logic [7:0] REG_WR_DATA,
  output logic       RD_STB,
  output logic       FRAME_ERR
`ifdef SPI_S_ERR_CNT_EN
  ,
  output logic [7:0] ERR_CNT
`endif
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, DATA, HOLD} state_t;

  logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   csn_last_q, sclk_last_q;
  logic                   csn_s, sclk_s, mosi_s;
  logic                   csn_rise, csn_fall, sclk_rise, sclk_fall;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [6:0] sh_q;
  logic       mode_q;
  logic [6:0] addr_q;
  logic [6:0] rd_sh_q;
  logic       first_fall_q;
  logic       miso_q, wr_stb_q, rd_stb_q, frame_err_q;
  logic [6:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [DEPTH];
  logic [7:0] err_cnt_q;

  logic       in_range, clear_hit;
  logic [7:0] wr_data_d, rd_val;

  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_rise  = csn_s & ~csn_last_q;
  assign csn_fall  = ~csn_s & csn_last_q;
  assign sclk_rise = sclk_s & ~sclk_last_q;
  assign sclk_fall = ~sclk_s & sclk_last_q;

  assign in_range  = ({1'b0, addr_q} < DEPTH_W);
  assign wr_data_d = {sh_q, mosi_s};
  assign rd_val    = in_range ? regs_q[addr_q[AW-1:0]] : 8'h00;

`ifdef SPI_S_ERR_CNT_EN
  assign clear_hit = (addr_q == 7'h7F) && (wr_data_d == 8'hA5);
  assign ERR_CNT   = err_cnt_q;
`else
  assign clear_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      csn_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_last_q  <= 1'b1;
      sclk_last_q <= 1'b0;
    end else begin
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], CSN};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      csn_last_q  <= csn_s;
      sclk_last_q <= sclk_s;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      mode_q       <= 1'b0;
      addr_q       <= '0;
      rd_sh_q      <= '0;
      first_fall_q <= 1'b0;
      miso_q       <= 1'b0;
      wr_stb_q     <= 1'b0;
      rd_stb_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RST_VAL;
    end else begin
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (csn_fall) begin
            state_q   <= HDR;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            miso_q    <= 1'b0;
          end
        end
        HDR: begin
          if (csn_rise) begin
            state_q     <= IDLE;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else if (sclk_rise) begin
            sh_q      <= {sh_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              mode_q       <= sh_q[6];
              addr_q       <= {sh_q[5:0], mosi_s};
              first_fall_q <= 1'b1;
              state_q      <= DATA;
            end
          end
        end
        DATA: begin
          // 16th rise wins over a coincident CSN rise: the frame is complete
          if (sclk_rise && bit_cnt_q == 4'd15) begin
            state_q <= csn_rise ? IDLE : HOLD;
            miso_q  <= 1'b0;
            if (mode_q) begin
              wr_stb_q  <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= wr_data_d;
              if (clear_hit) err_cnt_q <= '0;
              if (in_range && !clear_hit) regs_q[addr_q[AW-1:0]] <= wr_data_d;
            end
          end else if (csn_rise) begin
            state_q     <= IDLE;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else if (sclk_rise) begin
            sh_q      <= {sh_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (sclk_fall) begin
            first_fall_q <= 1'b0;
            if (!mode_q) begin
              if (first_fall_q) begin
                rd_sh_q  <= rd_val[6:0];
                miso_q   <= rd_val[7];
                rd_stb_q <= 1'b1;
              end else begin
                rd_sh_q <= {rd_sh_q[5:0], 1'b0};
                miso_q  <= rd_sh_q[6];
              end
            end
          end
        end
        HOLD: begin
          miso_q <= 1'b0;
          if (csn_rise) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO        = miso_q;
  assign BUSY        = (state_q != IDLE);
  assign REG_WR_STB  = wr_stb_q;
  assign REG_WR_ADDR = wr_addr_q;
  assign REG_WR_DATA = wr_data_q;
  assign RD_STB      = rd_stb_q;
  assign FRAME_ERR   = frame_err_q;

endmodule
